// File: rtl/edge_event_pkg.sv
// Shared types and defaults for the edge event scheduler.
// Build option: EDGE_EVENT_SCHEDULER_TIMESTAMP_EN enables edge timestamping.
package edge_event_pkg;

   localparam int N_CH_DEF = 4;
   localparam int TS_W_DEF = 16;
   localparam int CH_W_DEF = $clog2(N_CH_DEF);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } evt_state_t;

   // Event record at the default configuration
   typedef struct packed {
      logic [CH_W_DEF-1:0] ch;
      logic                etype;
      logic [TS_W_DEF-1:0] ts;
   } edge_evt_t;

endpackage

// File: rtl/edge_detector.sv
// Two-flop synchroniser followed by a registered edge detector.
// A change on din before posedge k gives edge_detected high from k+2 to k+3.
module edge_detector (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic edge_detected,
   output logic edge_rise
);

   logic [2:0] sync_r;

   // Synchronise the line and flag any change of the synchronised level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r        <= 3'b000;
         edge_detected <= 1'b0;
         edge_rise     <= 1'b0;
      end else begin
         sync_r        <= {sync_r[1:0], din};
         edge_detected <= sync_r[1] ^ sync_r[2];
         edge_rise     <= sync_r[1];
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 (mod N)
// and returns the first requesting line as one-hot grant and index.
module rr_arbiter #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_valid
);

   logic [W-1:0] cand_s;

   // Scan candidates in rotating priority order, first hit wins
   always_comb begin
      gnt       = {N{1'b0}};
      gnt_idx   = {W{1'b0}};
      gnt_valid = 1'b0;
      cand_s    = {W{1'b0}};
      for (int k = 1; k <= N; k++) begin
         cand_s = W'((int'(ptr) + k) % N);
         if (!gnt_valid && req[cand_s]) begin
            gnt[cand_s] = 1'b1;
            gnt_idx     = cand_s;
            gnt_valid   = 1'b1;
         end else begin
            gnt_valid = gnt_valid;
         end
      end
   end

endmodule

// File: rtl/edge_event_scheduler.sv
// Multichannel edge-event collector: qualified edges are latched as pending
// events and handed out round-robin on a valid/ready port.
// Build option: EDGE_EVENT_SCHEDULER_TIMESTAMP_EN adds the capture timestamp;
// without it evt_ts is tied to zero.
module edge_event_scheduler
   import edge_event_pkg::*;
#(
   parameter  int N_CH = N_CH_DEF,
   parameter  int TS_W = TS_W_DEF,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] data_in,
   input  logic [N_CH-1:0] ch_enable,
   input  logic [N_CH-1:0] rise_en,
   input  logic [N_CH-1:0] fall_en,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [CH_W-1:0] evt_ch,
   output logic            evt_type,
   output logic [TS_W-1:0] evt_ts,
   output logic [N_CH-1:0] overflow,
   input  logic            ovf_clr
);

   logic [N_CH-1:0] edge_det_s;
   logic [N_CH-1:0] edge_rise_s;
   logic [N_CH-1:0] qual_s;
   logic [N_CH-1:0] req_s;
   logic [N_CH-1:0] gnt_s;
   logic [N_CH-1:0] load_vec_s;
   logic [N_CH-1:0] ovf_set_s;
   logic [N_CH-1:0] accept_s;
   logic [CH_W-1:0] gnt_idx_s;
   logic            gnt_valid_s;
   logic            load_s;
   evt_state_t      state_r;
   evt_state_t      state_s;

   logic [N_CH-1:0] pend_r;
   logic [N_CH-1:0] pend_type_r;
   logic [CH_W-1:0] rr_ptr_r;

   for (genvar i = 0; i < N_CH; i++) begin : g_det
      edge_detector u_det (
         .clk           (clk),
         .rst_n         (rst_n),
         .din           (data_in[i]),
         .edge_detected (edge_det_s[i]),
         .edge_rise     (edge_rise_s[i])
      );
   end

   // A disabled channel neither captures nor competes for the grant
   assign qual_s     = edge_det_s & ch_enable & ((edge_rise_s & rise_en) | (~edge_rise_s & fall_en));
   assign req_s      = pend_r & ch_enable;
   assign load_vec_s = load_s ? gnt_s : {N_CH{1'b0}};
   // Oldest event is kept unless its slot is vacated in this very cycle
   assign ovf_set_s  = qual_s & pend_r & ~load_vec_s;
   assign accept_s   = qual_s & ~ovf_set_s;

   rr_arbiter #(.N(N_CH)) u_arb (
      .req       (req_s),
      .ptr       (rr_ptr_r),
      .gnt       (gnt_s),
      .gnt_idx   (gnt_idx_s),
      .gnt_valid (gnt_valid_s)
   );

   // Next-state and load decision for the presentation FSM
   always_comb begin
      state_s = state_r;
      load_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (gnt_valid_s) begin
               state_s = PRESENT;
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         PRESENT: begin
            if (evt_ready) begin
               load_s = gnt_valid_s;
               if (gnt_valid_s) begin
                  state_s = PRESENT;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = PRESENT;
            end
         end
         default: begin
            state_s = IDLE;
            load_s  = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Pending flags, captured edge polarity and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r      <= {N_CH{1'b0}};
         pend_type_r <= {N_CH{1'b0}};
         rr_ptr_r    <= CH_W'(N_CH - 1);
      end else begin
         pend_r      <= ((pend_r & ~load_vec_s) | accept_s) & ch_enable;
         pend_type_r <= (pend_type_r & ~accept_s) | (edge_rise_s & accept_s);
         if (load_s) begin
            rr_ptr_r <= gnt_idx_s;
         end
      end
   end

   // Registered event port; fields stay put until the next grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_ch    <= {CH_W{1'b0}};
         evt_type  <= 1'b0;
      end else begin
         evt_valid <= (state_s == PRESENT);
         if (load_s) begin
            evt_ch   <= gnt_idx_s;
            evt_type <= pend_type_r[gnt_idx_s];
         end
      end
   end

   // Sticky loss flags; a new loss beats a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= {N_CH{1'b0}};
      end else begin
         overflow <= (overflow & ~{N_CH{ovf_clr}}) | ovf_set_s;
      end
   end

`ifdef EDGE_EVENT_SCHEDULER_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt_r;
   logic [TS_W-1:0] pend_ts_r [N_CH];

   // Free-running timestamp, wraps silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt_r <= {TS_W{1'b0}};
      end else begin
         ts_cnt_r <= ts_cnt_r + TS_W'(1);
      end
   end

   // Capture the counter for each accepted edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            pend_ts_r[i] <= {TS_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (accept_s[i]) begin
               pend_ts_r[i] <= ts_cnt_r;
            end
         end
      end
   end

   // Timestamp of the presented event, loaded with the grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_ts <= {TS_W{1'b0}};
      end else begin
         if (load_s) begin
            evt_ts <= pend_ts_r[gnt_idx_s];
         end
      end
   end
`else
   assign evt_ts = {TS_W{1'b0}};
`endif

endmodule

// File: doc/edge_event_scheduler.md
Name: edge_event_scheduler

Overview:
- Multichannel edge-event collector and arbiter.
- One edge_detector instance per input line; qualified edges are latched as pending events.
- Pending events are granted round-robin and presented one at a time on a valid/ready event port, optionally with a capture timestamp.
- Sits between raw GPIO/status lines and the SoC interrupt/event FIFO.

Parameters:
N_CH, 4, number of monitored input lines (2..16)
TS_W, 16, timestamp counter width (used only with the timestamp feature)
CH_W, $clog2(N_CH), channel index width (derived; not overridable)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock, asynchronous, active-low
data_in  input  N_CH  raw monitored lines (synchronised internally by edge_detector)
ch_enable  input  N_CH  per-channel enable
rise_en  input  N_CH  accept rising edges on channel
fall_en  input  N_CH  accept falling edges on channel
evt_valid  output  1  event presented
evt_ready  input  1  consumer accepts event
evt_ch  output  CH_W  channel index of presented event
evt_type  output  1  0 falling, 1 rising
evt_ts  output  TS_W  timestamp of the edge
overflow  output  N_CH  sticky per-channel event-lost flags
ovf_clr  input  1  clears all overflow bits

Behaviour:
- Reset values: evt_valid=0, evt_ch=0, evt_type=0, evt_ts=0, overflow=0, all pending=0, rr pointer=N_CH-1 (ch0 has first priority), timestamp counter=0.
- Edge path latency:
  - data_in[i] changes before posedge k.
  - edge_detected[i] is high for exactly one cycle, between posedges k+2 and k+3.
  - The qualified edge is latched at posedge k+3.
- Qualified edge: edge_detected & ch_enable & (edge_type ? rise_en : fall_en). On it, pending[i]=1, type[i]=edge_type, ts[i]=counter value at that posedge.
- Pending collision: pending[i] already set and not loaded into the output register in the same cycle → new edge dropped (oldest kept), overflow[i]=1. If pending[i] is loaded in the same cycle, the new edge is latched and overflow is not set.
- ch_enable[i]=0 clears pending[i] on the next posedge. An event already presented is not retracted.
- FSM states:
  - IDLE: evt_valid=0. If any pending, select the first pending channel searching upward from rr_ptr+1 (modulo N_CH). Load evt_ch/type/ts, clear that pending bit, set rr_ptr to the granted channel, go to PRESENT.
  - PRESENT: evt_valid=1; evt_ch/type/ts held stable until evt_valid & evt_ready.
    - On the handshake, if any pending: load the next grant in the same cycle and stay in PRESENT (back-to-back, one event/cycle).
    - On the handshake with nothing pending: go to IDLE.
- First event latency: 1 cycle from pending set to evt_valid.
- overflow: set has priority over ovf_clr in the same cycle; ovf_clr clears only bits not being set.
- Timestamp counter: free-running, +1 per cycle, wraps 2^TS_W-1 → 0, no flag.
- Reset mid-operation: all state returns to reset values asynchronously; in-flight and pending events are lost; no spurious evt_valid after reset release. Edge detectors reset to 0, so a line held high at release produces one rising edge.

Optional Feature:
- Macro: EDGE_EVENT_SCHEDULER_TIMESTAMP_EN
- Defined: counter, per-channel ts storage and evt_ts path present as described.
- Undefined: counter and ts storage absent; evt_ts port still present, tied to 0; all other behaviour identical.

Decomposition:
- Package edge_event_pkg:
  - typedef evt_state_t {IDLE, PRESENT}
  - typedef edge_evt_t struct {ch, type, ts}
  - localparam defaults for N_CH/TS_W
- Sub-modules:
  - Existing edge_detector instantiated per channel via generate.
  - One natural new sub-module, rr_arbiter: N-bit request vector, pointer input, one-hot grant and index, combinational.

Test Plan:
- All enables=1, rise on ch2 at posedge 10 → pending at posedge 13, evt_valid at 14 with evt_ch=2, evt_type=1, evt_ts=13 (timestamp build); evt_ready=1 → evt_valid=0 next cycle.
- Simultaneous rising edges on ch0..ch3 with evt_ready=1 → four back-to-back events in order ch0,1,2,3. Repeat with rr_ptr=1 → order 2,3,0,1.
- evt_ready=0 while ch1 has an event presented and another pending, then a third edge on ch1 → overflow=4'b0010, stored event unchanged. ovf_clr in the same cycle as a new overflow on ch3 → overflow=4'b1000.
- rise_en[0]=0, fall_en[0]=1: toggle ch0 0→1→0 → only one event, evt_type=0. ch_enable[0]=0 with pending → event discarded, no evt_valid.
- rst_n asserted while evt_valid=1 and pending=4'b0110 → evt_valid=0 immediately, no events after release.
- Macro undefined: same as scenario 1 but evt_ts=0. TS_W=4 with macro defined: event at counter 15 then 16 cycles later → evt_ts=15, then wrapped value 15.
